// File: rtl/dac_val_ctrl_pkg.sv
// Shared constants and frame-FSM state encoding for the DAC code controller.
package dac_pkg;
    localparam int         FRAME_W   = 16;
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [7:0] DAC_MAX   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT_H = 3'd2,
        SHIFT_L = 3'd3,
        GAP     = 3'd4
    } frame_state_e;
endpackage

// File: rtl/dac_val_ctrl_if.sv
// 3-wire serial link to the AD5300-style DAC.
interface dac_val_ctrl_if;
    logic dac_sync_n;
    logic dac_sclk;
    logic dac_din;

    modport master (output dac_sync_n, output dac_sclk, output dac_din);
    modport slave  (input  dac_sync_n, input  dac_sclk, input  dac_din);
endinterface

// File: rtl/dac_val_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
module btn_debounce #(
    parameter int DEB_CNT = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEB_CNT + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CNT - 1))
                level_d = ~level_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= 2'b00;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw};
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;
endmodule

// File: rtl/dac_val_ctrl.sv
// Saturating 8-bit DAC code stepped by debounced buttons; each change is sent as a 16-bit SPI frame.
//
// state   | meaning
// IDLE    | no frame; waits for pending change
// LOAD    | frame word captured, SYNC low, first SCLK-high cycle
// SHIFT_H | SCLK high, current bit on DIN
// SHIFT_L | SCLK low, DAC has sampled on the falling edge
// GAP     | SYNC high spacing before the next frame
module dac_val_ctrl
    import dac_pkg::*;
#(
    parameter int DEB_CNT  = 20000,
    parameter int STEP     = 1,
    parameter int SCLK_DIV = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic [7:0]            dac_val,
    output logic                  busy,
    dac_val_ctrl_if.master        spi
);
    localparam int            TW     = $clog2(SCLK_DIV + 1);
    localparam logic [TW-1:0] DIV_M1 = TW'(SCLK_DIV - 1);
    localparam logic [TW-1:0] DIV_M2 = TW'((SCLK_DIV > 1) ? SCLK_DIV - 2 : 0);

    logic press_up, press_dn;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
        .clk(clk), .rst(rst), .btn_raw(btn_up), .press(press_up)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_dn (
        .clk(clk), .rst(rst), .btn_raw(btn_down), .press(press_dn)
    );

    logic [7:0]         dac_val_q, dac_val_d;
    logic [8:0]         sum9, diff9;
    logic               pending_q, pending_d;
    frame_state_e       state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [3:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               sync_n_q, sync_n_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               frame_on;

    assign sum9  = {1'b0, dac_val_q} + 9'(STEP);
    assign diff9 = {1'b0, dac_val_q} - 9'(STEP);

    always_comb begin
        dac_val_d = dac_val_q;
        if (press_up && !press_dn)
            dac_val_d = sum9[8] ? DAC_MAX : sum9[7:0];
        else if (press_dn && !press_up)
            dac_val_d = diff9[8] ? 8'h00 : diff9[7:0];
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = LOAD;
                    pending_d = 1'b0;
                    bit_d     = 4'd15;
                    shift_d   = {2'b00, PD_NORMAL, dac_val_q, 4'b0000};
                end
            end
            LOAD: begin
                // LOAD is already the first SCLK-high cycle of bit 15.
                if (SCLK_DIV == 1) begin
                    state_d = SHIFT_L;
                    tmr_d   = DIV_M1;
                end else begin
                    state_d = SHIFT_H;
                    tmr_d   = DIV_M2;
                end
            end
            SHIFT_H: begin
                if (tmr_q == '0) begin
                    state_d = SHIFT_L;
                    tmr_d   = DIV_M1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SHIFT_L: begin
                if (tmr_q == '0) begin
                    tmr_d = DIV_M1;
                    if (bit_q != 4'd0) begin
                        bit_d   = bit_q - 1'b1;
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        state_d = SHIFT_H;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0)
                    state_d = IDLE;
                else
                    tmr_d = tmr_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A change arriving while a frame is being loaded still needs its own frame.
        if (dac_val_d != dac_val_q)
            pending_d = 1'b1;
    end

    // Line outputs are registered from the next state so they never glitch.
    always_comb begin
        frame_on = (state_d == LOAD) || (state_d == SHIFT_H) || (state_d == SHIFT_L);
        sync_n_d = ~frame_on;
        sclk_d   = (state_d != SHIFT_L);
        din_d    = frame_on ? shift_d[FRAME_W-1] : 1'b0;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_val_q <= 8'h00;
            pending_q <= 1'b1;
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_q     <= 4'd0;
            shift_q   <= '0;
            sync_n_q  <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            dac_val_q <= dac_val_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sync_n_q  <= sync_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
        end
    end

    assign dac_val        = dac_val_q;
    assign busy           = busy_q;
    assign spi.dac_sync_n = sync_n_q;
    assign spi.dac_sclk   = sclk_q;
    assign spi.dac_din    = din_q;
endmodule
